fft_input_loader: RTL and testbench

//  Upstream loader for the radix-4 FFT core. Accepts a valid/ready stream of 16-bit real samples.

---
 rtl/fft_input_loader_pkg.sv | 24 ++
 rtl/fft_load_addr_gen.sv | 42 ++++
 rtl/fft_input_loader.sv | 164 ++++++++++++++++
 tb/tb_fft_input_loader.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_input_loader_pkg.sv
// ============================================================================
// fft_input_loader_pkg
// Shared frame geometry and state type for the FFT input loader.
// Revision: 1.0
// ============================================================================
`default_nettype none

package fft_input_loader_pkg;

  localparam int N_POINTS = 2048;  // frame length, 4 banks of 2**ADDR_W words
  localparam int DATA_W   = 16;    // two's complement sample width
  localparam int ADDR_W   = 9;     // per-bank address width
  localparam int CNT_W    = ADDR_W + 2;  // sample index inside a frame

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_START = 2'd2,
    ST_WAIT  = 2'd3
  } load_state_t;

endpackage

`default_nettype wire

// File: rtl/fft_load_addr_gen.sv
// ============================================================================
// fft_load_addr_gen
// Frame sample counter. The low ADDR_W bits are the bank address, the top two
// bits select the bank, so x[n], x[n+512], x[n+1024], x[n+1536] share an address.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fft_load_addr_gen
  import fft_input_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc,      // advance on an accepted, written sample
  input  logic              clr,      // restart the frame at sample 0
  output logic [ADDR_W-1:0] addr,
  output logic [3:0]        bank,     // one-hot bank write enable for this sample
  output logic              at_last   // counter sits on the final sample of a frame
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt;

  // Sample counter; wraps naturally from N_POINTS-1 back to 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CNT_ONE;
    end
  end

  assign addr    = cnt[ADDR_W-1:0];
  assign bank    = 4'b0001 << cnt[CNT_W-1 -: 2];
  assign at_last = &cnt;

endmodule

`default_nettype wire

// File: rtl/fft_input_loader.sv
// ============================================================================
// fft_input_loader
// Streams one 2048-sample frame into the radix-4 FFT core's four input banks,
// pulses the core start, then waits for a rising edge on the core ready.
// Optional feature macro: FFT_LOAD_LAST_EN (frame-length checking via last).
// Revision: 1.0
// ============================================================================
`default_nettype none

module fft_input_loader
  import fft_input_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] sample,
  input  logic              valid,
  output logic              ready,
  output logic [DATA_W-1:0] data,
  output logic [ADDR_W-1:0] addr_wr,
  output logic [3:0]        we,
  output logic              start,
  input  logic              fft_rdy,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic              last
);

  load_state_t       state, state_nxt;
  logic              beat;
  logic              wr;
  logic              cnt_inc;
  logic              cnt_clr;
  logic              rdy_q;
  logic              rdy_edge;
  logic [ADDR_W-1:0] cnt_addr;
  logic [3:0]        cnt_bank;
  logic              at_last;

  fft_load_addr_gen u_addr_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (cnt_inc),
    .clr     (cnt_clr),
    .addr    (cnt_addr),
    .bank    (cnt_bank),
    .at_last (at_last)
  );

  assign ready    = (state == ST_LOAD);
  assign busy     = (state != ST_IDLE);
  assign beat     = valid & ready;
  assign rdy_edge = fft_rdy & ~rdy_q;

`ifdef FFT_LOAD_LAST_EN
  logic flush, flush_nxt;
  logic set_err;

  // Next state and per-beat decisions, with frame-length checking against last.
  always_comb begin
    state_nxt = state;
    wr        = 1'b0;
    cnt_inc   = 1'b0;
    cnt_clr   = 1'b0;
    set_err   = 1'b0;
    flush_nxt = flush;
    case (state)
      ST_IDLE:  if (en) state_nxt = ST_LOAD;
      ST_LOAD: begin
        if (beat) begin
          if (flush) begin
            // Leftover samples of an over-long frame are swallowed up to its last.
            if (last) flush_nxt = 1'b0;
          end else if (last && !at_last) begin
            set_err = 1'b1;
            cnt_clr = 1'b1;
          end else begin
            wr      = 1'b1;
            cnt_inc = 1'b1;
            if (at_last) begin
              state_nxt = ST_START;
              if (!last) begin
                set_err   = 1'b1;
                flush_nxt = 1'b1;
              end
            end
          end
        end
      end
      ST_START: state_nxt = ST_WAIT;
      ST_WAIT:  if (rdy_edge) state_nxt = en ? ST_LOAD : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Sticky error and discard-mode flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err   <= 1'b0;
      flush <= 1'b0;
    end else begin
      flush <= flush_nxt;
      if (set_err) err <= 1'b1;
    end
  end
`else
  logic unused_last;
  assign unused_last = last;
  assign err         = 1'b0;

  // Next state and per-beat decisions; framing purely by sample count.
  always_comb begin
    state_nxt = state;
    wr        = 1'b0;
    cnt_inc   = 1'b0;
    cnt_clr   = 1'b0;
    case (state)
      ST_IDLE:  if (en) state_nxt = ST_LOAD;
      ST_LOAD: begin
        if (beat) begin
          wr      = 1'b1;
          cnt_inc = 1'b1;
          if (at_last) state_nxt = ST_START;
        end
      end
      ST_START: state_nxt = ST_WAIT;
      ST_WAIT:  if (rdy_edge) state_nxt = en ? ST_LOAD : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Core write port, start/done pulses and ready edge register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data    <= '0;
      addr_wr <= '0;
      we      <= 4'b0000;
      start   <= 1'b0;
      done    <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      we    <= wr ? cnt_bank : 4'b0000;
      if (wr) begin
        data    <= sample;
        addr_wr <= cnt_addr;
      end
      // Start lags the final write by one cycle so it lands before the core switches source.
      start <= (state == ST_START);
      done  <= (state == ST_WAIT) && rdy_edge;
      rdy_q <= fft_rdy;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fft_input_loader.sv
`timescale 1ns/1ps
`default_nettype none

module tb_fft_input_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] sample = '0;
  logic        valid = 1'b0;
  logic        ready;
  logic [15:0] data;
  logic [8:0]  addr_wr;
  logic [3:0]  we;
  logic        start;
  logic        fft_rdy = 1'b0;
  logic        busy;
  logic        done;
  logic        err;
  logic        last = 1'b0;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int wr_count = 0;
  int bad_we = 0;
  int start_count = 0;
  int done_count = 0;
  int last_we_cyc = 0;
  int start_cyc = 0;
  int done_cyc = 0;
  int rise_cyc = 0;
  logic [15:0] mem [0:3][0:511];

  fft_input_loader dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .sample  (sample),
    .valid   (valid),
    .ready   (ready),
    .data    (data),
    .addr_wr (addr_wr),
    .we      (we),
    .start   (start),
    .fft_rdy (fft_rdy),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .last    (last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Records the core-side memory image and pulse timing just after each edge.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (we != 4'b0000) begin
      wr_count++;
      last_we_cyc = cyc;
      case (we)
        4'b0001: mem[0][addr_wr] = data;
        4'b0010: mem[1][addr_wr] = data;
        4'b0100: mem[2][addr_wr] = data;
        4'b1000: mem[3][addr_wr] = data;
        default: bad_we++;
      endcase
    end
    if (start) begin
      start_count++;
      start_cyc = cyc;
    end
    if (done) begin
      done_count++;
      done_cyc = cyc;
    end
  end

  task automatic clear_image();
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 512; a++)
        mem[b][a] = 16'hdead;
    wr_count = 0;
  endtask

  // Expected image for a ramp x[n] = n: bank b, address a holds b*512 + a.
  task automatic check_ramp_image(input string tag);
    int bad = 0;
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 512; a++)
        if (mem[b][a] !== 16'(b * 512 + a)) bad++;
    check(tag, bad, 0);
  endtask

  task automatic send(input logic [15:0] s, input logic l, input int gap);
    int t = 0;
    @(negedge clk);
    valid = 1'b0;
    repeat (gap) @(negedge clk);
    valid  = 1'b1;
    sample = s;
    last   = l;
    while (!ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!ready) check("ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    valid = 1'b0;
    last  = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 20 && done_count < target; i++) @(negedge clk);
    check("done_seen", done_count, target);
  endtask

  task automatic ready_edge_pulse();
    @(negedge clk);
    fft_rdy = 1'b0;
    repeat (5) @(negedge clk);
    fft_rdy  = 1'b1;
    rise_cyc = cyc;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with valid held high and loader disarmed.
    valid = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data", data, 0);
    check("rst_addr", addr_wr, 0);
    check("rst_we", we, 0);
    check("rst_start", start, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_ready", ready, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_ready", ready, 0);
    check("idle_we", we, 0);
    valid = 1'b0;

    // Ramp frame, back to back; core ready already high before WAIT.
    fft_rdy = 1'b1;
    en = 1'b1;
    clear_image();
    for (int n = 0; n < 2048; n++) begin
      send(16'(n), n == 2047, 0);
      if (n == 0) begin
        check("b0_we", we, 4'b0001); check("b0_addr", addr_wr, 0); check("b0_data", data, 0);
      end
      if (n == 511) begin
        check("b511_we", we, 4'b0001); check("b511_addr", addr_wr, 511);
      end
      if (n == 512) begin
        check("b512_we", we, 4'b0010); check("b512_addr", addr_wr, 0); check("b512_data", data, 512);
      end
      if (n == 2047) begin
        check("b2047_we", we, 4'b1000); check("b2047_addr", addr_wr, 511);
      end
    end
    repeat (3) @(negedge clk);
    check("ramp_start_cnt", start_count, 1);
    check("ramp_start_lag", start_cyc - last_we_cyc, 1);
    check("ramp_wr_cnt", wr_count, 2048);
    check_ramp_image("ramp_image");
    check("wait_ready", ready, 0);
    check("wait_busy", busy, 1);

    // Level already high on entering WAIT must not finish the frame.
    repeat (5) @(negedge clk);
    check("no_done_level", done_count, 0);
    ready_edge_pulse();
    wait_done(1);
    check("done_lag", done_cyc - rise_cyc, 1);
    repeat (2) @(negedge clk);
    check("done_once", done_count, 1);
    check("rearm_ready", ready, 1);

    // Gappy frame; disarm mid-frame, frame still completes.
    clear_image();
    for (int n = 0; n < 2048; n++) begin
      if (n == 1000) en = 1'b0;
      send(16'(n), n == 2047, int'($urandom_range(0, 1)));
    end
    repeat (3) @(negedge clk);
    check("gap_wr_cnt", wr_count, 2048);
    check_ramp_image("gap_image");
    check("gap_start_cnt", start_count, 2);
    ready_edge_pulse();
    wait_done(2);
    repeat (3) @(negedge clk);
    check("disarm_ready", ready, 0);
    check("disarm_busy", busy, 0);
    check("onehot_we", bad_we, 0);

    // Reset mid-frame discards the partial frame.
    en = 1'b1;
    for (int n = 0; n <= 1000; n++) send(16'(n), 1'b0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_we", we, 0);
    check("midrst_busy", busy, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_no_start", start_count, 2);
`ifdef FFT_LOAD_LAST_EN
    send(16'h1234, 1'b0, 0);
    check("restart_we", we, 4'b0001);
    check("restart_addr", addr_wr, 0);
    check("restart_data", data, 16'h1234);

    // Early last: error, frame dropped, no start.
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 100; n++) send(16'(n), n == 99, 0);
    check("early_we", we, 0);
    check("early_err", err, 1);
    repeat (3) @(negedge clk);
    check("early_no_start", start_count, 2);
    for (int n = 0; n < 2048; n++) send(16'(n), n == 2047, 0);
    repeat (3) @(negedge clk);
    check("after_early_start", start_count, 3);
    ready_edge_pulse();
    wait_done(3);
    // Late last: error kept, start still issued.
    for (int n = 0; n < 2048; n++) send(16'(n), 1'b0, 0);
    repeat (3) @(negedge clk);
    check("late_start", start_count, 4);
    check("late_err", err, 1);
`else
    // last is ignored in the count-framed build.
    send(16'h1234, 1'b1, 0);
    check("restart_we", we, 4'b0001);
    check("restart_addr", addr_wr, 0);
    check("restart_data", data, 16'h1234);
    check("err_tied", err, 0);
    check("restart_ready", ready, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
